// File: rtl/ov7670_cfg_sequencer.sv
// ov7670_cfg_sequencer
//   Walks a fixed OV7670 register table after reset and feeds the SCCB byte
//   master one register write per entry: register-address byte, then the
//   value byte, chained in a single transaction to DEV_ADDR.
//   Build option: define OV_CFG_DELAY_EN to treat reg_addr 8'hFF entries as
//   "wait val ms" markers instead of register writes.
//
// Master handshake: i_ready high means the master is idle and can take a
// request. o_enable high is the request. The master signals acceptance by
// dropping i_ready while o_enable is high, and signals the end of the byte by
// raising i_ready again. o_enable is held high across the register-address
// byte so the master chains the value byte without a STOP, and is dropped
// once the value byte is accepted.
module ov7670_cfg_sequencer #(
  parameter int unsigned CLK_FREQ_HZ = 25000000,
  parameter logic [6:0]  DEV_ADDR    = 7'h21,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned PWRUP_MS    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_ready,
  output logic [6:0] o_addr,
  output logic [7:0] o_din,
  output logic       o_enable,
  output logic       o_rd_wr,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_index,
  output logic [2:0] o_state
);

  localparam int unsigned TICK_CYCLES = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
  localparam int unsigned MS_W        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICK_CYCLES - 1);
  localparam logic [7:0] LAST_IDX     = 8'(NUM_REGS - 1);
  localparam logic [7:0] PWRUP_CNT    = 8'(PWRUP_MS);

  typedef enum logic [2:0] {
    S_PWRUP    = 3'd0,
    S_FETCH    = 3'd1,
    S_REQ_REG  = 3'd2,
    S_WAIT_REG = 3'd3,
    S_REQ_VAL  = 3'd4,
    S_WAIT_VAL = 3'd5,
    S_DELAY    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      index_q;
  logic [7:0]      val_q;
  logic [7:0]      din_q;
  logic            en_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      dly_q;
  logic [MS_W-1:0] ms_q;

  logic [15:0]     rom_entry;
  logic [7:0]      rom_reg;
  logic [7:0]      rom_val;
  logic            skip_entry;
  logic            ms_tick;
  logic            dly_over;
  logic            is_last;
  logic            advance;

  // Register table ROM; index 8 is a 3 ms settle marker when delay entries
  // are enabled, otherwise it is written to the unused register 0xFF.
  always_comb begin
    rom_entry = 16'h0000;
    case (index_q)
      8'd0:    rom_entry = 16'h1280; // COM7 soft reset
      8'd1:    rom_entry = 16'h1101; // CLKRC prescaler
      8'd2:    rom_entry = 16'h1204; // COM7 RGB output
      8'd3:    rom_entry = 16'h0C00; // COM3
      8'd4:    rom_entry = 16'h3E00; // COM14
      8'd5:    rom_entry = 16'h40D0; // COM15 RGB565 full range
      8'd6:    rom_entry = 16'h8C00; // RGB444 off
      8'd7:    rom_entry = 16'h0400; // COM1
      8'd8:    rom_entry = 16'hFF03; // settle marker / dummy write
      8'd9:    rom_entry = 16'h3A04; // TSLB
      8'd10:   rom_entry = 16'h1418; // COM9 AGC ceiling
      8'd11:   rom_entry = 16'h4FB3; // MTX1
      8'd12:   rom_entry = 16'h50B3; // MTX2
      8'd13:   rom_entry = 16'h523D; // MTX4
      8'd14:   rom_entry = 16'h53A7; // MTX5
      8'd15:   rom_entry = 16'h54E4; // MTX6
      default: rom_entry = 16'h0000;
    endcase
  end

  assign rom_reg  = rom_entry[15:8];
  assign rom_val  = rom_entry[7:0];
  assign ms_tick  = (ms_q == MS_LAST);
  assign dly_over = (dly_q == 8'd0) || (ms_tick && (dly_q == 8'd1));
  assign is_last  = (index_q == LAST_IDX);

  // Decide whether the fetched entry is a delay marker rather than a write.
  always_comb begin
    skip_entry = 1'b0;
`ifdef OV_CFG_DELAY_EN
    skip_entry = (rom_reg == 8'hFF);
`endif
  end

  // Next-state logic for the table walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PWRUP:    if (dly_over) state_d = S_FETCH;
      S_FETCH:    state_d = skip_entry ? S_DELAY : S_REQ_REG;
      S_REQ_REG:  if (en_q && !i_ready) state_d = S_WAIT_REG;
      S_WAIT_REG: if (i_ready) state_d = S_REQ_VAL;
      S_REQ_VAL:  if (!i_ready) state_d = S_WAIT_VAL;
      S_WAIT_VAL: begin
        if (i_ready) begin
          if (index_q == 8'd0) state_d = S_DELAY;
          else if (is_last)    state_d = S_DONE;
          else                 state_d = S_FETCH;
        end
      end
      S_DELAY:    if (dly_over) state_d = is_last ? S_DONE : S_FETCH;
      S_DONE:     if (i_start) state_d = S_FETCH;
      default:    state_d = S_PWRUP;
    endcase
  end

  // Index moves on only when leaving a finished entry for the next fetch.
  assign advance = (state_d == S_FETCH) &&
                   ((state_q == S_WAIT_VAL) || (state_q == S_DELAY));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_PWRUP;
    else          state_q <= state_d;
  end

  // Millisecond prescaler and ms countdown, active only while waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ms_q  <= '0;
      dly_q <= PWRUP_CNT;
    end else begin
      if ((state_q == S_PWRUP) || (state_q == S_DELAY)) begin
        ms_q <= ms_tick ? '0 : ms_q + 1'b1;
        if (ms_tick && (dly_q != 8'd0)) dly_q <= dly_q - 8'd1;
      end else begin
        ms_q <= '0;
      end
      if ((state_q == S_WAIT_VAL) && (state_d == S_DELAY)) dly_q <= 8'd1;
      if ((state_q == S_FETCH) && skip_entry)              dly_q <= rom_val;
    end
  end

  // Entry latch, byte mux, request flag and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      index_q <= 8'd0;
      val_q   <= 8'd0;
      din_q   <= 8'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_d != S_DONE);
      done_q <= (state_d == S_DONE);
      if (advance) index_q <= index_q + 8'd1;
      case (state_q)
        S_FETCH: begin
          val_q <= rom_val;
          if (!skip_entry) din_q <= rom_reg;
        end
        S_REQ_REG:  if (i_ready) en_q <= 1'b1;
        S_WAIT_REG: if (i_ready) din_q <= val_q;
        S_REQ_VAL:  if (!i_ready) en_q <= 1'b0;
        S_DONE:     if (i_start) index_q <= 8'd0;
        default: ;
      endcase
    end
  end

  assign o_addr   = DEV_ADDR;
  assign o_rd_wr  = 1'b0;
  assign o_din    = din_q;
  assign o_enable = en_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_index  = index_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed bench for ov7670_cfg_sequencer at a 1 kHz clock (1 ms = 1 cycle).
// The bench plays the SCCB master: it accepts each byte by dropping i_ready
// and completes it by raising i_ready again.
module tb_ov7670_cfg_sequencer;

  localparam int NREG = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [6:0] addr;
  logic [7:0] din;
  logic       enable;
  logic       rd_wr;
  logic       busy;
  logic       done;
  logic [7:0] index;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int gap;

  logic [7:0] exp_reg [NREG];
  logic [7:0] exp_val [NREG];

  ov7670_cfg_sequencer #(
    .CLK_FREQ_HZ (1000),
    .DEV_ADDR    (7'h21),
    .NUM_REGS    (NREG),
    .PWRUP_MS    (2)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_ready  (ready),
    .o_addr   (addr),
    .o_din    (din),
    .o_enable (enable),
    .o_rd_wr  (rd_wr),
    .o_busy   (busy),
    .o_done   (done),
    .o_index  (index),
    .o_state  (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next request; gap = number of rising edges taken.
  task automatic wait_enable(output int g);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!enable && g < 2000);
    chk("enable_seen", {31'd0, enable}, 32'd1);
  endtask

  // Register-address byte: check request, accept it, hold busy for hold cycles.
  task automatic serve_reg(input int idx, input int hold, output int g);
    logic stable;
    wait_enable(g);
    chk("reg_index", {24'd0, index}, idx);
    chk("reg_byte", {24'd0, din}, {24'd0, exp_reg[idx]});
    chk("dev_addr", {25'd0, addr}, 32'h21);
    chk("rd_wr", {31'd0, rd_wr}, 32'd0);
    ready  = 1'b0;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (din !== exp_reg[idx] || index !== 8'(idx) || enable !== 1'b1) stable = 1'b0;
    end
    chk("reg_hold_stable", {31'd0, stable}, 32'd1);
    ready = 1'b1;
  endtask

  // Value byte: must follow with o_enable still high, then drop after accept.
  task automatic serve_val(input int idx, input bit release_bus);
    @(negedge clk);
    chk("val_byte", {24'd0, din}, {24'd0, exp_val[idx]});
    chk("enable_chained", {31'd0, enable}, 32'd1);
    ready = 1'b0;
    @(negedge clk);
    chk("enable_dropped", {31'd0, enable}, 32'd0);
    chk("val_index", {24'd0, index}, idx);
    @(negedge clk);
    if (release_bus) ready = 1'b1;
  endtask

  initial begin
    exp_reg = '{8'h12, 8'h11, 8'h12, 8'h0C, 8'h3E, 8'h40, 8'h8C, 8'h04,
                8'hFF, 8'h3A, 8'h14, 8'h4F, 8'h50, 8'h52, 8'h53, 8'h54};
    exp_val = '{8'h80, 8'h01, 8'h04, 8'h00, 8'h00, 8'hD0, 8'h00, 8'h00,
                8'h03, 8'h04, 8'h18, 8'hB3, 8'hB3, 8'h3D, 8'hA7, 8'hE4};

    // Step 1: reset values
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_enable", {31'd0, enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_index", {24'd0, index}, 32'd0);
    chk("rst_din", {24'd0, din}, 32'd0);
    chk("rst_addr", {25'd0, addr}, 32'h21);
    chk("rst_rd_wr", {31'd0, rd_wr}, 32'd0);

    // Step 2: power-up wait. 2 ms ticks, FETCH, REQ_REG -> enable on edge 4.
    rst_n = 1'b1;
    serve_reg(0, 3, gap);
    chk("first_gap", gap, 32'd4);
    chk("run_busy", {31'd0, busy}, 32'd1);
    serve_val(0, 1'b1);

    // Step 3: walk the table. Normal gap: FETCH, REQ_REG, enable = 3 edges.
    // After COM7 one extra 1 ms delay edge -> 4. Entry 3 stalls 500 cycles.
    // Entry 2 is preceded by an i_start pulse that must be ignored.
    for (int idx = 1; idx < NREG; idx++) begin
`ifdef OV_CFG_DELAY_EN
      if (idx == 8) continue;
`endif
      if (idx == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      serve_reg(idx, (idx == 3) ? 500 : 2, gap);
      if (idx == 1) chk("post_com7_gap", gap, 32'd4);
`ifdef OV_CFG_DELAY_EN
      // FETCH(8), DELAY x3 ms, FETCH(9), REQ_REG, enable = 7 edges
      else if (idx == 9) chk("marker_delay_gap", gap, 32'd7);
`endif
      else if (idx != 2) chk("entry_gap", gap, 32'd3);
      serve_val(idx, 1'b1);
    end

    // Step 4: table complete
    @(negedge clk);
    chk("done_flag", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    chk("done_index", {24'd0, index}, NREG - 1);
    repeat (5) @(negedge clk);
    chk("done_idle_enable", {31'd0, enable}, 32'd0);
    chk("done_hold", {31'd0, done}, 32'd1);

    // Step 5: i_start in S_DONE reruns from index 0 without power-up wait
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rerun_busy", {31'd0, busy}, 32'd1);
    chk("rerun_done", {31'd0, done}, 32'd0);
    chk("rerun_index", {24'd0, index}, 32'd0);
    serve_reg(0, 2, gap);
    chk("rerun_gap", gap, 32'd2);
    serve_val(0, 1'b1);
    for (int idx = 1; idx < 5; idx++) begin
      serve_reg(idx, 2, gap);
      serve_val(idx, 1'b1);
    end

    // Step 6: reset while entry 5 sits in S_WAIT_VAL; reset is asynchronous
    serve_reg(5, 2, gap);
    serve_val(5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_enable", {31'd0, enable}, 32'd0);
    chk("async_rst_index", {24'd0, index}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd1);
    chk("async_rst_din", {24'd0, din}, 32'd0);
    ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serve_reg(0, 2, gap);
    chk("restart_gap", gap, 32'd4);
    serve_val(0, 1'b1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
- Upstream feeder for the I2C/SCCB byte master; walks a fixed OV7670 register table after reset and issues one register write per entry.
- Each entry is {reg_addr[7:0], value[7:0]} and is sent as two chained master transactions to device DEV_ADDR: the register-address byte, then the value byte.
- Signals completion to the capture pipeline so pixel capture starts only once the sensor is configured.

Parameters:
- CLK_FREQ_HZ, 25000000, i_clk frequency; the 1 ms tick period is CLK_FREQ_HZ/1000 cycles.
- DEV_ADDR, 7'h21, 7-bit SCCB write address of the OV7670.
- NUM_REGS, 16, number of valid table entries (indices 0..NUM_REGS-1), max 255.
- PWRUP_MS, 2, ms to wait after reset before the first transaction.

Ports:
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, reset; one clock; reset is asynchronous and active-low.
- i_start, in, 1, one-cycle pulse that re-runs the full table; honoured only in S_DONE.
- i_ready, in, 1, master idle flag (high = master can accept a request).
- o_addr, out, 7, device address to master; constant DEV_ADDR.
- o_din, out, 8, byte to write (register address or value).
- o_enable, out, 1, transaction request to master.
- o_rd_wr, out, 1, constant 0 (write).
- o_busy, out, 1, high from reset release until table complete.
- o_done, out, 1, high in S_DONE.
- o_index, out, 8, index of the entry currently being sent (debug).

Behaviour:
- Reset values: o_din=0, o_enable=0, o_busy=1, o_done=0, o_index=0, state=S_PWRUP, ms counter=0.
- Table: internal case ROM indexed by o_index; entry 0 is {8'h12, 8'h80} (COM7 soft reset); entries at index >= NUM_REGS are never fetched.
- S_PWRUP: count PWRUP_MS ms ticks, then go to S_FETCH.
- S_FETCH: latch the entry into reg_q/val_q; o_din<=reg_q; go to S_REQ_REG.
- S_REQ_REG: wait for i_ready=1, then assert o_enable. Hold o_enable until i_ready falls (request accepted), then go to S_WAIT_REG.
- S_WAIT_REG: o_enable stays high so the master chains without STOP. When i_ready rises, o_din<=val_q and go to S_REQ_VAL.
- S_REQ_VAL: keep o_enable high until i_ready falls, then drop o_enable and go to S_WAIT_VAL.
- S_WAIT_VAL: on i_ready=1:
  - if the entry was index 0 (COM7 reset), go to S_DELAY with 1 ms;
  - else if o_index==NUM_REGS-1, go to S_DONE;
  - else o_index+1 and go to S_FETCH.
- S_DELAY: count the programmed ms, then advance the index as in S_WAIT_VAL.
- S_DONE: o_busy=0, o_done=1. On i_start: o_index<=0, o_busy=1, o_done=0, go to S_FETCH (no power-up wait).
- i_start outside S_DONE is ignored.
- i_ready high for a single cycle while o_enable is asserted counts as acceptance only when followed by a fall; an i_ready that never falls keeps the sequencer waiting indefinitely (no timeout).
- Async reset mid-transaction immediately clears o_enable and restarts from S_PWRUP at index 0.
- ms counter: ceil(log2(CLK_FREQ_HZ/1000)) bits, wraps to 0 on each tick; delay count is 8 bits.

Optional Feature:
- Macro: OV_CFG_DELAY_EN.
- Defined: an entry with reg_addr==8'hFF is not sent. The sequencer goes straight from S_FETCH to S_DELAY for val_q ms (0 = no delay, advance next cycle), then advances.
- Undefined: 8'hFF entries are written like any other register, and only the fixed post-COM7 1 ms delay exists.

Test Plan:
- Reset release with CLK_FREQ_HZ=1000 (1 ms = 1 cycle), PWRUP_MS=2 -> first o_enable no earlier than 2 ticks after reset; o_din=8'h12, o_addr=7'h21, o_rd_wr=0.
- Behavioural master model acks every byte -> for each entry, o_din shows reg then value; o_enable is continuous across both bytes. After NUM_REGS entries, o_done=1, o_busy=0, o_index=NUM_REGS-1.
- After entry 0 completes -> no new o_enable for 1 ms (1 cycle at test freq, 25000 cycles at default).
- Master holds i_ready low for 500 cycles -> sequencer stalls with o_din stable and no index advance.
- Assert i_rst_n low during S_WAIT_VAL of entry 5 -> o_enable=0 the same cycle; after release, sequence restarts at index 0 with the power-up wait.
- OV_CFG_DELAY_EN defined, table entry {8'hFF, 8'd3} -> no transaction for that entry; next entry's o_enable appears after 3 ms. In S_DONE, an i_start pulse reruns from index 0.
